enc_tx_sequencer: RTL and testbench

//  - Transmit-side scheduler feeding the 8B/10B encoder one character per clk: 8-bit byte plus K flag.
//  - Runs comma alignment after reset, then frames packets taken from a valid/ready byte stream.
//  - Frame format: SOF, data bytes, EOF. Between frames it sends idle commas and inserts periodic skip characters.
//  - Sits between the packet source and the encoder's data_buffer/K inputs.

---
 rtl/enc_seq_pkg.sv | 30 +++
 rtl/enc_seq_crc8.sv | 35 +++
 rtl/enc_tx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_enc_tx_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_seq_pkg.sv
// Shared K-codes, FSM state encoding and the CRC-8 byte step for the TX sequencer.
// The CRC step is MSB first over polynomial x^8+x^2+x+1.
package enc_seq_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] K23_7 = 8'hF7;  // fill on source underrun
    localparam logic [7:0] K28_0 = 8'h1C;  // clock-compensation skip

    typedef enum logic [2:0] {
        ALIGN,
        IDLE,
        DATA,
        CRC,
        EOF,
        EOF_DROP,
        DROP
    } state_t;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/enc_seq_crc8.sv
// Running CRC-8 over frame payload bytes; clr wins over en so SOF always starts from zero.
// Only instantiated when ENC_SEQ_CRC8_EN is defined.
module enc_seq_crc8
    import enc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_next(crc_q, din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/enc_tx_sequencer.sv
// 8B/10B TX character scheduler: comma alignment, SOF/data/EOF framing, idle commas and skips.
// Define ENC_SEQ_CRC8_EN to append a CRC-8 data character before EOF on non-truncated frames.
module enc_tx_sequencer
    import enc_seq_pkg::*;
#(
    parameter int ALIGN_LEN   = 16,
    parameter int SKIP_PERIOD = 1024,
    parameter int MAX_LEN     = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       link_up,
    output logic       err_underrun,
    output logic       err_len
);

    localparam int AW = $clog2(ALIGN_LEN + 1);
    localparam int SW = $clog2(SKIP_PERIOD);
    localparam int LW = $clog2(MAX_LEN + 1);

`ifdef ENC_SEQ_CRC8_EN
    localparam state_t LAST_NEXT = CRC;
`else
    localparam state_t LAST_NEXT = EOF;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] align_cnt_q;
    logic [SW-1:0] skip_cnt_q;
    logic [LW-1:0] len_cnt_q;
    logic          skip_pend_q, link_up_q, err_u_q, err_l_q;
    logic [7:0]    enc_data_q, enc_data_d;
    logic          enc_k_q, enc_k_d;
    logic          xfer, align_done, skip_tc, at_max, skip_take, sof;

    assign xfer       = s_valid & s_ready;
    assign align_done = (align_cnt_q == AW'(ALIGN_LEN - 1));
    assign skip_tc    = link_up_q && (skip_cnt_q == SW'(SKIP_PERIOD - 1));
    assign at_max     = (len_cnt_q == LW'(MAX_LEN - 1));
    assign skip_take  = (state_q == IDLE) && skip_pend_q;
    // A pending skip always goes out before a new SOF so it never lands inside a frame.
    assign sof        = (state_q == IDLE) && !skip_pend_q && en && s_valid;

`ifdef ENC_SEQ_CRC8_EN
    logic [7:0] crc;

    enc_seq_crc8 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (sof),
        .en  ((state_q == DATA) && xfer),
        .din (s_data),
        .crc (crc)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALIGN:    if (align_done) state_d = IDLE;
            IDLE:     if (sof) state_d = DATA;
            DATA: begin
                if (xfer) begin
                    if (s_last)      state_d = LAST_NEXT;
                    else if (at_max) state_d = EOF_DROP;
                end
            end
            CRC:      state_d = EOF;
            EOF:      state_d = IDLE;
            EOF_DROP: state_d = DROP;
            DROP:     if (xfer && s_last) state_d = IDLE;
            default:  state_d = ALIGN;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        enc_data_d = K28_5;
        enc_k_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (skip_pend_q)          enc_data_d = K28_0;
                else if (en && s_valid)   enc_data_d = K27_7;
            end
            DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    enc_data_d = s_data;
                    enc_k_d    = 1'b0;
                end else begin
                    enc_data_d = K23_7;
                end
            end
`ifdef ENC_SEQ_CRC8_EN
            CRC: begin
                enc_data_d = crc;
                enc_k_d    = 1'b0;
            end
`endif
            EOF, EOF_DROP: enc_data_d = K29_7;
            DROP:          s_ready    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_cnt_q <= '0;
            link_up_q   <= 1'b0;
            skip_cnt_q  <= '0;
            skip_pend_q <= 1'b0;
            len_cnt_q   <= '0;
            err_u_q     <= 1'b0;
            err_l_q     <= 1'b0;
            enc_data_q  <= K28_5;
            enc_k_q     <= 1'b1;
        end else begin
            enc_data_q <= enc_data_d;
            enc_k_q    <= enc_k_d;
            if (state_q == ALIGN) begin
                align_cnt_q <= align_cnt_q + AW'(1);
                if (align_done) link_up_q <= 1'b1;
            end
            if (link_up_q) begin
                skip_cnt_q <= skip_tc ? '0 : skip_cnt_q + SW'(1);
            end
            // A new terminal count outranks clearing an older request in the same cycle.
            if (skip_tc)        skip_pend_q <= 1'b1;
            else if (skip_take) skip_pend_q <= 1'b0;
            if (sof || state_q == EOF || state_q == EOF_DROP) begin
                len_cnt_q <= '0;
            end else if (state_q == DATA && xfer) begin
                len_cnt_q <= len_cnt_q + LW'(1);
            end
            if (state_q == DATA && !s_valid)                   err_u_q <= 1'b1;
            if (state_q == DATA && xfer && !s_last && at_max)  err_l_q <= 1'b1;
        end
    end

    assign enc_data     = enc_data_q;
    assign enc_k        = enc_k_q;
    assign link_up      = link_up_q;
    assign err_underrun = err_u_q;
    assign err_len      = err_l_q;

endmodule

// File: tb/tb_enc_tx_sequencer.sv
// Bench for enc_tx_sequencer with ALIGN_LEN=4, SKIP_PERIOD=16, MAX_LEN=4.
// Characters are handled as 9-bit {k, data}.
module tb_enc_tx_sequencer;

    localparam int ALEN = 4;
    localparam int SPER = 16;
    localparam int MLEN = 4;

    localparam logic [8:0] C_BC = 9'h1BC;
    localparam logic [8:0] C_FB = 9'h1FB;
    localparam logic [8:0] C_FD = 9'h1FD;
    localparam logic [8:0] C_F7 = 9'h1F7;
    localparam logic [8:0] C_1C = 9'h11C;

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];

    typedef struct {
        bit         en;
        bit         v;
        logic [7:0] d;
        bit         l;
        bit         rdy;
        logic [8:0] ch;
        bit         eu;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       link_up;
    logic       err_underrun;
    logic       err_len;

    int         errs = 0;
    int         checks = 0;
    int         lu_cnt = 0;
    bit         exp_eu, exp_el;
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];
    vec_t       tbl[$];

    enc_tx_sequencer #(.ALIGN_LEN(ALEN), .SKIP_PERIOD(SPER), .MAX_LEN(MLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .enc_data     (enc_data),
        .enc_k        (enc_k),
        .link_up      (link_up),
        .err_underrun (err_underrun),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input bq_t b);
        logic [7:0] c = 8'h00;
        logic       fb;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ b[i][k];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // Expected characters of one frame, with idle commas and skips removed.
    function automatic void model_frame(input bq_t b, input iq_t g);
        bq_t sent;
        int  n = (b.size() < MLEN) ? b.size() : MLEN;
        exp_q.push_back(C_FB);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int j = 0; j < g[i]; j++) exp_q.push_back(C_F7);
                if (g[i] > 0) exp_eu = 1'b1;
            end
            exp_q.push_back({1'b0, b[i]});
            sent.push_back(b[i]);
        end
        if (b.size() > MLEN) begin
            exp_el = 1'b1;
        end else begin
`ifdef ENC_SEQ_CRC8_EN
            exp_q.push_back({1'b0, crc8(sent)});
`endif
        end
        exp_q.push_back(C_FD);
    endfunction

    function automatic void row(bit e, bit v, logic [7:0] d, bit l, bit rdy, logic [8:0] ch, bit eu);
        vec_t r;
        r.en = e; r.v = v; r.d = d; r.l = l; r.rdy = rdy; r.ch = ch; r.eu = eu;
        tbl.push_back(r);
    endfunction

    task automatic tick();
        @(negedge clk);
        cap_q.push_back({enc_k, enc_data});
        if (link_up) lu_cnt++;
    endtask

    task automatic do_reset();
        int n = 0;
        int bad = 0;
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_char", {enc_k, enc_data}, C_BC);
        chk("rst_ready", s_ready, 0);
        chk("rst_link", link_up, 0);
        chk("rst_errs", {err_underrun, err_len}, 0);
        rst = 1'b0;
        while (!link_up && n < 50) begin
            @(negedge clk);
            n++;
            if ({enc_k, enc_data} != C_BC) bad++;
        end
        chk("align_len", n, ALEN);
        chk("align_chars", bad, 0);
        cap_q.delete();
        exp_q.delete();
        lu_cnt = 1;
        exp_eu = 1'b0;
        exp_el = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit last);
        int t = 0;
        s_data = d; s_valid = 1'b1; s_last = last;
        while (!s_ready && t < 64) begin
            tick();
            t++;
        end
        chk("handshake", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input bq_t b, input iq_t g);
        foreach (b[i]) begin
            if (i > 0) repeat (g[i]) tick();
            drive_byte(b[i], i == b.size() - 1);
        end
    endtask

    task automatic mk_zeros(input int n, output iq_t g);
        g.delete();
        for (int i = 0; i < n; i++) g.push_back(0);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, int'(cap_q.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk(name, cap_q[i], exp_q[i]);
        end
    endtask

    initial begin
        bq_t b;
        iq_t g;
        logic [8:0] filt[$];
        int         skips, infr_bad, len;
        bit         in_frame;

        // Frame A0..A2 back-to-back, then 10,11 with a two-cycle source gap.
`ifdef ENC_SEQ_CRC8_EN
        logic [7:0] crc_a, crc_b;
        b = {8'hA0, 8'hA1, 8'hA2};
        crc_a = crc8(b);
        b = {8'h10, 8'h11};
        crc_b = crc8(b);
`endif
        row(1, 1, 8'hA0, 0, 0, C_FB,   0);
        row(1, 1, 8'hA0, 0, 1, 9'h0A0, 0);
        row(1, 1, 8'hA1, 0, 1, 9'h0A1, 0);
        row(1, 1, 8'hA2, 1, 1, 9'h0A2, 0);
`ifdef ENC_SEQ_CRC8_EN
        row(1, 0, 8'h00, 0, 0, {1'b0, crc_a}, 0);
`endif
        row(1, 0, 8'h00, 0, 0, C_FD,   0);
        row(1, 0, 8'h00, 0, 0, C_BC,   0);
        row(1, 1, 8'h10, 0, 0, C_FB,   0);
        row(1, 1, 8'h10, 0, 1, 9'h010, 0);
        row(1, 0, 8'h00, 0, 1, C_F7,   1);
        row(1, 0, 8'h00, 0, 1, C_F7,   1);
        row(1, 1, 8'h11, 1, 1, 9'h011, 1);
`ifdef ENC_SEQ_CRC8_EN
        row(1, 0, 8'h00, 0, 0, {1'b0, crc_b}, 1);
`endif
        row(1, 0, 8'h00, 0, 0, C_FD,   1);
        row(1, 0, 8'h00, 0, 0, C_BC,   1);

        do_reset();
        foreach (tbl[j]) begin
            en = tbl[j].en; s_valid = tbl[j].v; s_data = tbl[j].d; s_last = tbl[j].l;
            chk("tbl_ready", s_ready, tbl[j].rdy);
            @(negedge clk);
            chk("tbl_char", {enc_k, enc_data}, tbl[j].ch);
            chk("tbl_err_underrun", err_underrun, tbl[j].eu);
        end
        chk("tbl_err_len", err_len, 0);

        // Truncation: 6 bytes with MAX_LEN=4, tail dropped, then a 1-byte frame.
        do_reset();
        en = 1'b1;
        b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'h31 + 8'(i));
        mk_zeros(6, g);
        send_frame(b, g);
        exp_q.push_back(C_FB);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, b[i]});
        exp_q.push_back(C_FD);
        exp_q.push_back(C_BC);
        exp_q.push_back(C_BC);
        b = {8'h01};
        mk_zeros(1, g);
        send_frame(b, g);
        model_frame(b, g);
        repeat (3) tick();
        cmp_stream("trunc_stream");
        chk("trunc_err_len", err_len, 1);
        chk("trunc_err_underrun", err_underrun, 0);

        // en low holds off SOF; a skip falling due mid-frame waits for the frame to end.
        do_reset();
        en = 1'b0; s_valid = 1'b1; s_data = 8'h50; s_last = 1'b0;
        repeat (12) begin
            chk("en_gate_ready", s_ready, 0);
            tick();
        end
        for (int i = 0; i < 12; i++) exp_q.push_back(C_BC);
        en = 1'b1;
        b = {8'h50, 8'h51, 8'h52, 8'h53};
        mk_zeros(4, g);
        send_frame(b, g);
        model_frame(b, g);
        exp_q.push_back(C_1C);
        b = {8'h60};
        mk_zeros(1, g);
        send_frame(b, g);
        model_frame(b, g);
        repeat (4) tick();
        cmp_stream("skip_stream");
        chk("maxlen_exact_err_len", err_len, 0);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        en = 1'b1; s_valid = 1'b1; s_data = 8'h70; s_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midframe_ready", s_ready, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_char", {enc_k, enc_data}, C_BC);
        chk("arst_link", link_up, 0);
        chk("arst_ready", s_ready, 0);

        // Random frames against the stream model.
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            len = $urandom_range(1, 6);
            b.delete();
            g.delete();
            for (int i = 0; i < len; i++) begin
                b.push_back(8'($urandom));
                g.push_back(i == 0 ? 0 : int'($urandom_range(0, 1)));
            end
            model_frame(b, g);
            send_frame(b, g);
        end
        repeat (40) tick();
        skips = 0;
        infr_bad = 0;
        in_frame = 1'b0;
        foreach (cap_q[i]) begin
            if (cap_q[i] == C_FB) in_frame = 1'b1;
            if (cap_q[i] == C_FD) in_frame = 1'b0;
            if (cap_q[i] == C_1C) begin
                skips++;
                if (in_frame) infr_bad++;
            end else if (cap_q[i] != C_BC) begin
                filt.push_back(cap_q[i]);
            end
        end
        chk("rand_stream_len", filt.size(), exp_q.size());
        for (int i = 0; i < filt.size() && i < exp_q.size(); i++) begin
            chk("rand_stream", filt[i], exp_q[i]);
        end
        chk("rand_skip_count", skips, (lu_cnt - 2) / SPER);
        chk("rand_skip_in_frame", infr_bad, 0);
        chk("rand_err_underrun", err_underrun, int'(exp_eu));
        chk("rand_err_len", err_len, int'(exp_el));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
